// File: rtl/simple_acc_pkg.sv
// Shared types for the simple-acc multiplier streamer.
package simple_acc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_DONE
    } streamer_state_e;

endpackage

// File: rtl/simple_stride_gen.sv
// Operand address-style generator: loads a base value and advances by a latched stride.
module simple_stride_gen
    import simple_acc_pkg::*;
#(
    parameter int DataWidth = 64
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 load_i,
    input  logic [DataWidth-1:0] base_i,
    input  logic [DataWidth-1:0] stride_i,
    input  logic                 step_i,
    output logic [DataWidth-1:0] value_o
);

    logic [DataWidth-1:0] stride_q;

    // Load wins over step; stepping wraps modulo 2^DataWidth.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            value_o  <= '0;
            stride_q <= '0;
        end else if (load_i) begin
            value_o  <= base_i;
            stride_q <= stride_i;
        end else if (step_i) begin
            value_o  <= value_o + stride_q;
        end
    end

endmodule

// File: rtl/simple_mul_streamer.sv
// Streams (a, b) operand pairs to a single-entry multiplier and accumulates its results.
module simple_mul_streamer
    import simple_acc_pkg::*;
#(
    parameter int DataWidth  = 64,
    parameter int CountWidth = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic [DataWidth-1:0]  a_base_i,
    input  logic [DataWidth-1:0]  a_stride_i,
    input  logic [DataWidth-1:0]  b_base_i,
    input  logic [DataWidth-1:0]  b_stride_i,
    input  logic [CountWidth-1:0] len_i,
    output logic [DataWidth-1:0]  a_o,
    output logic [DataWidth-1:0]  b_o,
    output logic                  a_valid_o,
    input  logic                  a_ready_i,
    output logic                  b_valid_o,
    input  logic                  b_ready_i,
    input  logic [DataWidth-1:0]  result_i,
    input  logic                  result_valid_i,
    output logic                  result_ready_o,
    output logic [DataWidth-1:0]  acc_o,
    output logic [CountWidth-1:0] res_count_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_o
);

    streamer_state_e state_q, state_d;
    logic [CountWidth-1:0] len_q;
    logic start_job, start_empty, issue_accept, result_accept, last_result;

    assign start_job     = (state_q == ST_IDLE) && start_i && (len_i != '0);
    assign start_empty   = (state_q == ST_IDLE) && start_i && (len_i == '0);
    assign issue_accept  = (state_q == ST_ISSUE) && a_ready_i && b_ready_i;
    assign result_accept = (state_q == ST_WAIT) && result_valid_i;
    assign last_result   = (res_count_o + CountWidth'(1)) == len_q;

    assign a_valid_o      = (state_q == ST_ISSUE);
    assign b_valid_o      = (state_q == ST_ISSUE);
    assign result_ready_o = (state_q == ST_WAIT);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (start_job) state_d = ST_ISSUE;
            ST_ISSUE: if (issue_accept) state_d = ST_WAIT;
            ST_WAIT:  if (result_accept) state_d = last_result ? ST_DONE : ST_ISSUE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // busy/done are registered copies of the next state so they line up with state_q.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            len_q       <= '0;
            res_count_o <= '0;
            acc_o       <= '0;
            err_o       <= 1'b0;
            done_o      <= 1'b0;
            busy_o      <= 1'b0;
        end else begin
            state_q <= state_d;
            done_o  <= (state_d == ST_DONE) || start_empty;
            busy_o  <= (state_d != ST_IDLE);
            if (start_job || start_empty) begin
                len_q       <= len_i;
                res_count_o <= '0;
                acc_o       <= '0;
                err_o       <= 1'b0;
            end else begin
                if (result_accept) begin
                    acc_o       <= acc_o + result_i;
                    res_count_o <= res_count_o + CountWidth'(1);
                end
                if ((state_q == ST_ISSUE) && ((a_ready_i ^ b_ready_i) || result_valid_i)) begin
                    err_o <= 1'b1;
                end
            end
        end
    end

    simple_stride_gen #(.DataWidth(DataWidth)) u_a_gen (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .load_i  (start_job),
        .base_i  (a_base_i),
        .stride_i(a_stride_i),
        .step_i  (result_accept),
        .value_o (a_o)
    );

    simple_stride_gen #(.DataWidth(DataWidth)) u_b_gen (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .load_i  (start_job),
        .base_i  (b_base_i),
        .stride_i(b_stride_i),
        .step_i  (result_accept),
        .value_o (b_o)
    );

endmodule

// File: tb/tb_simple_mul_streamer.sv
// Bench for simple_mul_streamer: 1-cycle multiplier sink model plus an arithmetic reference model.
module tb_simple_mul_streamer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [63:0] a_base, a_stride, b_base, b_stride;
    logic [15:0] len;
    logic [63:0] a_o, b_o, result_i, acc_o;
    logic        a_valid_o, a_ready_i, b_valid_o, b_ready_i;
    logic        result_valid_i, result_ready_o;
    logic [15:0] res_count_o;
    logic        busy_o, done_o, err_o;

    logic        auto_ready, man_a, man_b, hold_result, inj_valid;
    logic [63:0] inj_data, sink_data;
    logic        sink_valid;

    logic [63:0] exp_a_base, exp_a_stride, exp_b_base, exp_b_stride;
    logic [15:0] exp_len;
    int          accept_idx, done_cnt, valid_cnt;
    int          total = 0;
    int          bad = 0;

    always #5 clk = ~clk;

    simple_mul_streamer dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .start_i       (start),
        .a_base_i      (a_base),
        .a_stride_i    (a_stride),
        .b_base_i      (b_base),
        .b_stride_i    (b_stride),
        .len_i         (len),
        .a_o           (a_o),
        .b_o           (b_o),
        .a_valid_o     (a_valid_o),
        .a_ready_i     (a_ready_i),
        .b_valid_o     (b_valid_o),
        .b_ready_i     (b_ready_i),
        .result_i      (result_i),
        .result_valid_i(result_valid_i),
        .result_ready_o(result_ready_o),
        .acc_o         (acc_o),
        .res_count_o   (res_count_o),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .err_o         (err_o)
    );

    assign a_ready_i      = auto_ready ? (a_valid_o && b_valid_o) : man_a;
    assign b_ready_i      = auto_ready ? (a_valid_o && b_valid_o) : man_b;
    assign result_valid_i = inj_valid | (sink_valid & ~hold_result);
    assign result_i       = inj_valid ? inj_data : sink_data;

    // Multiplier sink: registers the product one cycle after accepting operands.
    always @(posedge clk) begin
        if (rst) begin
            sink_valid <= 1'b0;
            sink_data  <= '0;
        end else if (a_valid_o && a_ready_i && b_valid_o && b_ready_i) begin
            sink_valid <= 1'b1;
            sink_data  <= a_o * b_o;
        end else if (result_valid_i && result_ready_o) begin
            sink_valid <= 1'b0;
        end
    end

    task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] ref_acc(input logic [63:0] ab, input logic [63:0] as,
                                            input logic [63:0] bb, input logic [63:0] bs,
                                            input int n);
        logic [63:0] sum = '0;
        for (int i = 0; i < n; i++) sum += (ab + 64'(i) * as) * (bb + 64'(i) * bs);
        return sum;
    endfunction

    // Operand handshakes are checked against base + k*stride for the k-th accept.
    always @(negedge clk) begin
        #2;
        if (!rst && a_valid_o && a_ready_i && b_valid_o && b_ready_i) begin
            check_output("op_a", a_o, exp_a_base + 64'(accept_idx) * exp_a_stride);
            check_output("op_b", b_o, exp_b_base + 64'(accept_idx) * exp_b_stride);
            check_output("op_valid_pair", 64'(b_valid_o), 64'(a_valid_o));
            accept_idx++;
        end
        if (done_o) done_cnt++;
        if (a_valid_o || b_valid_o) valid_cnt++;
    end

    task automatic apply_stimulus(input logic [63:0] ab, input logic [63:0] as,
                                  input logic [63:0] bb, input logic [63:0] bs,
                                  input logic [15:0] n);
        a_base = ab; a_stride = as; b_base = bb; b_stride = bs; len = n;
        exp_a_base = ab; exp_a_stride = as; exp_b_base = bb; exp_b_stride = bs; exp_len = n;
        accept_idx = 0; done_cnt = 0; valid_cnt = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic finish_job(input string tag, input logic exp_err);
        logic [63:0] exp_acc;
        int c = 0;
        exp_acc = ref_acc(exp_a_base, exp_a_stride, exp_b_base, exp_b_stride, int'(exp_len));
        while (!done_o && c < 300) begin
            @(negedge clk);
            c++;
        end
        check_output({tag, "_done"}, 64'(done_o), 64'd1);
        check_output({tag, "_acc"}, acc_o, exp_acc);
        check_output({tag, "_count"}, 64'(res_count_o), 64'(exp_len));
        check_output({tag, "_err"}, 64'(err_o), 64'(exp_err));
        check_output({tag, "_busy"}, 64'(busy_o), 64'(exp_len != 0));
        @(negedge clk);
        #3;
        check_output({tag, "_done_pulse"}, 64'(done_cnt), 64'd1);
        check_output({tag, "_idle_busy"}, 64'(busy_o), 64'd0);
        check_output({tag, "_acc_hold"}, acc_o, exp_acc);
        check_output({tag, "_count_hold"}, 64'(res_count_o), 64'(exp_len));
    endtask

    initial begin
        int c;
        rst = 1'b1; start = 1'b0; len = '0;
        a_base = '0; a_stride = '0; b_base = '0; b_stride = '0;
        auto_ready = 1'b1; man_a = 1'b0; man_b = 1'b0;
        hold_result = 1'b0; inj_valid = 1'b0; inj_data = '0;
        exp_a_base = '0; exp_a_stride = '0; exp_b_base = '0; exp_b_stride = '0; exp_len = '0;
        accept_idx = 0; done_cnt = 0; valid_cnt = 0;
        repeat (3) @(negedge clk);
        check_output("rst_acc", acc_o, 64'd0);
        check_output("rst_a", a_o, 64'd0);
        check_output("rst_flags", {58'd0, a_valid_o, b_valid_o, result_ready_o, busy_o, done_o, err_o}, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        $display("[TB] basic job len=4");
        apply_stimulus(64'd2, 64'd1, 64'd3, 64'd0, 16'd4);
        finish_job("basic", 1'b0);
        check_output("basic_acc_42", acc_o, 64'd42);
        check_output("basic_valid_cycles", 64'(valid_cnt), 64'd4);

        $display("[TB] empty job");
        apply_stimulus(64'd5, 64'd5, 64'd5, 64'd5, 16'd0);
        finish_job("empty", 1'b0);
        check_output("empty_no_valid", 64'(valid_cnt), 64'd0);

        $display("[TB] result stall");
        apply_stimulus(64'd5, 64'd2, 64'd7, 64'd1, 16'd2);
        hold_result = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_output("stall_valid", 64'(a_valid_o), 64'd0);
            check_output("stall_acc", acc_o, 64'd0);
        end
        hold_result = 1'b0;
        finish_job("stall", 1'b0);

        $display("[TB] wrap cases");
        apply_stimulus(64'h1_0000_0000, 64'd0, 64'h1_0000_0000, 64'd0, 16'd2);
        finish_job("wrap_prod", 1'b0);
        apply_stimulus(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd1, 64'd0, 16'd2);
        finish_job("wrap_op", 1'b0);

        $display("[TB] one-sided ready");
        auto_ready = 1'b0; man_a = 1'b1; man_b = 1'b0;
        apply_stimulus(64'd3, 64'd0, 64'd4, 64'd0, 16'd1);
        repeat (3) @(negedge clk);
        check_output("half_ready_err", 64'(err_o), 64'd1);
        check_output("half_ready_hold", 64'(a_valid_o), 64'd1);
        check_output("half_ready_acc", 64'(accept_idx), 64'd0);
        auto_ready = 1'b1; man_a = 1'b0;
        finish_job("half_ready", 1'b1);

        $display("[TB] result during issue");
        auto_ready = 1'b0;
        apply_stimulus(64'd6, 64'd0, 64'd7, 64'd0, 16'd1);
        inj_valid = 1'b1; inj_data = 64'd99;
        @(negedge clk);
        check_output("inj_err", 64'(err_o), 64'd1);
        check_output("inj_ready", 64'(result_ready_o), 64'd0);
        check_output("inj_acc", acc_o, 64'd0);
        inj_valid = 1'b0; auto_ready = 1'b1;
        finish_job("inj", 1'b1);

        $display("[TB] reset mid-job");
        apply_stimulus(64'd1, 64'd1, 64'd1, 64'd1, 16'd8);
        c = 0;
        while (!result_ready_o && c < 20) begin
            @(negedge clk);
            c++;
        end
        check_output("midrst_in_wait", 64'(result_ready_o), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        check_output("midrst_a", a_o, 64'd0);
        check_output("midrst_b", b_o, 64'd0);
        check_output("midrst_acc", acc_o, 64'd0);
        check_output("midrst_flags", {42'd0, res_count_o, a_valid_o, b_valid_o, result_ready_o, busy_o, done_o, err_o}, 64'd0);
        rst = 1'b0;
        @(negedge clk);
        apply_stimulus(64'd9, 64'd0, 64'd9, 64'd0, 16'd1);
        finish_job("after_rst", 1'b0);

        $display("[TB] random jobs");
        for (int j = 0; j < 5; j++) begin
            apply_stimulus({$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
                           {$urandom, $urandom}, 16'($urandom_range(1, 6)));
            finish_job("rand", 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
